fault_event_logger: RTL and testbench
=====================================

Name: fault_event_logger

Overview:
- Downstream stage of the threshold alarm monitor. Consumes the monitor's alarm_output and fault_capture signals.
- Each rising edge of the alarm is logged as one event: captured fault value, active data_mode and a free-running timestamp.
- Events are buffered in a first-word-fall-through FIFO that software drains over a valid/ready interface.
- Also provides an interrupt, an occupancy count and a saturating overflow counter.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- TS_WIDTH, 16, timestamp counter width in bits.
- DATA_WIDTH, 8, fault value width; matches the monitor's fault_capture.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous active-low reset.
- log_enable  input  1  1 = detected events are pushed; 0 = events ignored (not counted as overflow).
- alarm_in  input  1  alarm level from the monitor.
- fault_data  input  DATA_WIDTH  fault value from the monitor; sampled in the edge cycle.
- mode_in  input  1  monitor data_mode (0 unsigned, 1 signed); stored with the event.
- clear  input  1  synchronous flush of the FIFO and overflow_count.
- rd_ready  input  1  consumer accepts the head entry.
- rd_valid  output  1  FIFO non-empty; head entry is presented.
- rd_data  output  DATA_WIDTH  head entry fault value.
- rd_timestamp  output  TS_WIDTH  head entry timestamp.
- rd_mode  output  1  head entry mode bit.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_count  output  8  events dropped because the FIFO was full; saturates at 255.
- irq  output  1  registered; high while the FIFO holds at least one entry.

Behaviour:
- Reset (async, reset=0) clears: alarm_in delay flop, timestamp counter, pointers, fifo_count, overflow_count, irq. All outputs read 0; rd_valid=0.
- Memory contents are not reset. rd_data/rd_timestamp/rd_mode are don't-care while rd_valid=0.
- Timestamp: TS_WIDTH counter that increments every cycle after reset and wraps 2^TS_WIDTH-1 -> 0. It is unaffected by clear and log_enable.
- Edge detect: edge = alarm_in & ~alarm_d, where alarm_d is the registered alarm_in.
  - alarm_d resets to 0, so alarm_in=1 in the first cycle after reset counts as an edge.
  - A held-high alarm produces exactly one event.
- Logged entry = {mode_in, timestamp, fault_data}, all values as sampled in the edge cycle. The timestamp is the pre-increment value.
- push_req = edge & log_enable.
- pop = rd_valid & rd_ready.
- Push accepted when fifo_count < DEPTH, or when fifo_count == DEPTH and pop occurs in the same cycle (full + pop + push: count stays DEPTH).
- Push rejected (full, no pop): entry is dropped and overflow_count increments by 1, holding at 255.
- Empty + push: entry becomes visible on rd_* with rd_valid=1 the next cycle. There is no same-cycle bypass, and pop is impossible while empty.
- fifo_count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- rd_* are driven from memory at the read pointer (first-word fall-through) and are stable while rd_valid=1 and rd_ready=0.
- irq <= (fifo_count_next != 0); it rises one cycle after the first push and falls in the cycle after the last pop.
- clear=1 has priority over push and pop in the same cycle:
  - pointers, fifo_count and overflow_count go to 0; irq goes to 0 next cycle;
  - an edge in the clear cycle is discarded;
  - the edge detector and timestamp continue normally.
- Reset asserted mid-operation aborts immediately. Queued entries are lost and the timestamp restarts at 0.

Test Plan:
- Reset, then alarm_in 0->1 at timestamp 5 with fault_data=0xA3, mode_in=1 -> next cycle rd_valid=1, rd_data=0xA3, rd_timestamp=5, rd_mode=1, fifo_count=1, irq=1. alarm_in held high 10 more cycles -> fifo_count stays 1.
- With rd_ready=0, generate 8 edges with fault_data 0x10..0x17 -> fifo_count=8. Generate 2 more edges -> overflow_count=2. Drain with rd_ready=1 -> values read back 0x10..0x17 in order; then rd_valid=0 and irq=0 one cycle after the last pop.
- FIFO full and rd_ready=1 in the same cycle as an edge with fault_data=0x55 -> fifo_count stays 8, overflow_count unchanged, and 0x55 is the last value drained.
- log_enable=0 during 3 edges -> fifo_count=0 and overflow_count=0. Then clear=1 in a cycle holding 4 entries plus an edge -> next cycle fifo_count=0, overflow_count=0, rd_valid=0.
- TS_WIDTH=4: edge at cycle 17 after reset -> rd_timestamp=1 (wrap). Force 300 overflows -> overflow_count=255.
- Assert reset with 3 entries queued -> rd_valid, fifo_count, irq and overflow_count read 0 immediately. After release, the first edge carries the timestamp counted from 0.

Source files
------------

// File: rtl/fault_event_logger.sv
// Fault event logger: each rising alarm edge is captured with mode and timestamp into a
// first-word-fall-through FIFO, with occupancy, saturating overflow count and level interrupt.
`timescale 1ns/1ps
module fault_event_logger #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TS_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    log_enable,
    input  logic                    alarm_in,
    input  logic [DATA_WIDTH-1:0]   fault_data,
    input  logic                    mode_in,
    input  logic                    clear,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [TS_WIDTH-1:0]     rd_timestamp,
    output logic                    rd_mode,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [7:0]              overflow_count,
    output logic                    irq
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 1 + TS_WIDTH + DATA_WIDTH;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic                alarm_q;
    logic [TS_WIDTH-1:0] ts_q;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [7:0]          ovf_q, ovf_d;
    logic                irq_q;
    logic [EW-1:0]       mem [DEPTH];

    logic alarm_edge, push_req, pop, full, push, mem_we;

    assign rd_valid       = (count_q != '0);
    assign fifo_count     = count_q;
    assign overflow_count = ovf_q;
    assign irq            = irq_q;
    assign {rd_mode, rd_timestamp, rd_data} = mem[rd_ptr_q];

    always_comb begin
        alarm_edge = alarm_in & ~alarm_q;
        full       = (count_q == FULL_COUNT);
        pop        = rd_valid & rd_ready;
        push_req   = alarm_edge & log_enable;
        // A full FIFO still takes the new entry when the head leaves in the same cycle.
        push       = push_req & (~full | pop);
        mem_we     = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = '0;
        end else begin
            if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (push_req && !push && ovf_q != 8'hFF) begin
                ovf_d = ovf_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alarm_q  <= 1'b0;
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            alarm_q  <= alarm_in;
            ts_q     <= ts_q + TS_WIDTH'(1);
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_q    <= (count_d != '0);
        end
    end

    // Storage is left unreset; rd_* are don't-care while empty.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= {mode_in, ts_q, fault_data};
        end
    end
endmodule

// File: tb/tb_fault_event_logger.sv
// Bench for fault_event_logger: directed steps against a scoreboard model of the FIFO,
// plus a TS_WIDTH=4 instance for timestamp wrap and overflow saturation.
`timescale 1ns/1ps
module tb_fault_event_logger;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        log_enable = 1'b1, alarm_in = 1'b0, mode_in = 1'b0, clear = 1'b0;
    logic        rd_ready = 1'b0;
    logic [7:0]  fault_data = '0;
    logic        rd_valid, rd_mode, irq;
    logic [7:0]  rd_data, overflow_count;
    logic [15:0] rd_timestamp;
    logic [3:0]  fifo_count;

    logic        s_log_enable = 1'b1, s_alarm = 1'b0, s_mode = 1'b0, s_clear = 1'b0;
    logic        s_rd_ready = 1'b0;
    logic [7:0]  s_fault_data = '0;
    logic        s_rd_valid, s_rd_mode, s_irq;
    logic [7:0]  s_rd_data, s_overflow_count;
    logic [3:0]  s_rd_timestamp;
    logic [3:0]  s_fifo_count;

    always #5 clock = ~clock;

    fault_event_logger dut (
        .clock(clock), .reset(reset), .log_enable(log_enable), .alarm_in(alarm_in),
        .fault_data(fault_data), .mode_in(mode_in), .clear(clear), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_timestamp(rd_timestamp),
        .rd_mode(rd_mode), .fifo_count(fifo_count), .overflow_count(overflow_count),
        .irq(irq)
    );

    fault_event_logger #(.DEPTH(8), .TS_WIDTH(4), .DATA_WIDTH(8)) dut_small (
        .clock(clock), .reset(reset), .log_enable(s_log_enable), .alarm_in(s_alarm),
        .fault_data(s_fault_data), .mode_in(s_mode), .clear(s_clear),
        .rd_ready(s_rd_ready), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
        .rd_timestamp(s_rd_timestamp), .rd_mode(s_rd_mode), .fifo_count(s_fifo_count),
        .overflow_count(s_overflow_count), .irq(s_irq)
    );

    typedef struct packed {
        logic        mode;
        logic [15:0] ts;
        logic [7:0]  data;
    } ent_t;

    ent_t        sb[$];
    logic        m_alarm_d = 1'b0;
    logic [15:0] m_ts = '0;
    int          m_ovf = 0;
    int          passed = 0;
    int          total = 0;
    logic [7:0]  last_rd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        sb.delete();
        m_alarm_d = 1'b0;
        m_ts = '0;
        m_ovf = 0;
    endtask

    // One clock of the main DUT: score the pop/push, advance, then check status outputs.
    task automatic cycle();
        ent_t e;
        logic alarm_edge, full, do_pop;
        alarm_edge = alarm_in && !m_alarm_d;
        full       = (sb.size() == 8);
        do_pop     = (sb.size() != 0) && rd_ready && !clear;
        if (clear) begin
            sb.delete();
            m_ovf = 0;
        end else begin
            if (do_pop) begin
                e = sb.pop_front();
                chk("pop_valid", rd_valid, 1);
                chk("pop_data", rd_data, e.data);
                chk("pop_ts", rd_timestamp, e.ts);
                chk("pop_mode", rd_mode, e.mode);
                last_rd = rd_data;
            end
            if (alarm_edge && log_enable) begin
                if (!full || do_pop) begin
                    e.mode = mode_in;
                    e.ts   = m_ts;
                    e.data = fault_data;
                    sb.push_back(e);
                end else if (m_ovf != 255) begin
                    m_ovf++;
                end
            end
        end
        m_alarm_d = alarm_in;
        m_ts = m_ts + 16'd1;
        @(posedge clock);
        #1;
        chk("rd_valid", rd_valid, (sb.size() != 0));
        chk("fifo_count", fifo_count, sb.size());
        chk("irq", irq, (sb.size() != 0));
        chk("overflow_count", overflow_count, m_ovf);
    endtask

    task automatic pulse(input logic [7:0] d, input logic m);
        fault_data = d;
        mode_in = m;
        alarm_in = 1'b1;
        cycle();
        alarm_in = 1'b0;
        cycle();
    endtask

    task automatic s_pulse(input logic [7:0] d);
        s_fault_data = d;
        s_alarm = 1'b1;
        cycle();
        s_alarm = 1'b0;
        cycle();
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", rd_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow_count, 0);
        chk("rst_irq", irq, 0);
        reset = 1'b1;
        model_reset();

        // First event at timestamp 5, then a held-high alarm.
        repeat (5) cycle();
        fault_data = 8'hA3;
        mode_in = 1'b1;
        alarm_in = 1'b1;
        cycle();
        chk("first_valid", rd_valid, 1);
        chk("first_data", rd_data, 8'hA3);
        chk("first_ts", rd_timestamp, 16'd5);
        chk("first_mode", rd_mode, 1);
        chk("first_count", fifo_count, 1);
        chk("first_irq", irq, 1);
        repeat (10) cycle();
        chk("hold_count", fifo_count, 1);

        // Narrow timestamp wraps: edge sampled at cycle 17 carries 1.
        for (int i = 0; i < 8 && m_ts != 16'd17; i++) cycle();
        s_fault_data = 8'h3C;
        s_alarm = 1'b1;
        cycle();
        s_alarm = 1'b0;
        chk("wrap_valid", s_rd_valid, 1);
        chk("wrap_ts", s_rd_timestamp, 4'd1);
        chk("wrap_data", s_rd_data, 8'h3C);

        alarm_in = 1'b0;
        rd_ready = 1'b1;
        cycle();
        rd_ready = 1'b0;
        chk("drain1_irq", irq, 0);
        chk("drain1_count", fifo_count, 0);

        // Fill, overflow twice, then full + pop + push.
        for (int i = 0; i < 8; i++) pulse(8'h10 + 8'(i), i[0]);
        chk("full_count", fifo_count, 8);
        pulse(8'h70, 1'b0);
        pulse(8'h71, 1'b1);
        chk("ovf_two", overflow_count, 2);
        rd_ready = 1'b1;
        fault_data = 8'h55;
        alarm_in = 1'b1;
        cycle();
        rd_ready = 1'b0;
        alarm_in = 1'b0;
        chk("fpp_count", fifo_count, 8);
        chk("fpp_ovf", overflow_count, 2);
        cycle();
        rd_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) cycle();
        rd_ready = 1'b0;
        chk("last_drained", last_rd, 8'h55);
        chk("drained_valid", rd_valid, 0);
        chk("drained_irq", irq, 0);

        // Clear resets overflow; disabled logging ignores edges.
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("clear_ovf", overflow_count, 0);
        log_enable = 1'b0;
        for (int i = 0; i < 3; i++) pulse(8'h20 + 8'(i), 1'b0);
        chk("disabled_count", fifo_count, 0);
        chk("disabled_ovf", overflow_count, 0);
        log_enable = 1'b1;
        for (int i = 0; i < 4; i++) pulse(8'h30 + 8'(i), 1'b1);
        chk("four_count", fifo_count, 4);
        clear = 1'b1;
        alarm_in = 1'b1;
        rd_ready = 1'b1;
        cycle();
        clear = 1'b0;
        alarm_in = 1'b0;
        rd_ready = 1'b0;
        chk("clr_count", fifo_count, 0);
        chk("clr_ovf", overflow_count, 0);
        chk("clr_valid", rd_valid, 0);
        chk("clr_irq", irq, 0);
        cycle();

        // Overflow counter saturates.
        for (int i = 0; i < 310; i++) s_pulse(8'(i));
        chk("sat_ovf", s_overflow_count, 255);
        chk("sat_count", s_fifo_count, 8);

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 3; i++) pulse(8'h40 + 8'(i), 1'b0);
        chk("pre_rst_count", fifo_count, 3);
        reset = 1'b0;
        #1;
        chk("arst_valid", rd_valid, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_irq", irq, 0);
        chk("arst_ovf", overflow_count, 0);
        chk("arst_s_ovf", s_overflow_count, 0);
        chk("arst_s_count", s_fifo_count, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        repeat (3) cycle();
        fault_data = 8'hC7;
        alarm_in = 1'b1;
        cycle();
        alarm_in = 1'b0;
        chk("post_rst_ts", rd_timestamp, 16'd3);
        chk("post_rst_data", rd_data, 8'hC7);
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
